b2t: RTL and testbench
======================

# b2t

Binary-to-thermometer decoder for the DPLL frequency-locking block (FLB) decoder path. It converts an unsigned binary code into a thermometer word in which the count of ones equals the input value. That word drives unit-weighted elements, such as a DAC or DCO cell array. The output is registered so downstream cells see a glitch-free, single-transition update.

## Interface
- BIN_W, default 4: binary input width; legal range 1..8.
- THERMO_W, default 2**BIN_W (16): thermometer output width; fixed at 2**BIN_W and not independently overridable.
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- binary  in  BIN_W  unsigned code to decode.
- bin_valid  in  1  qualifies `binary`; when low, the input is ignored.
- thermo  out  THERMO_W  registered thermometer code.
- thermo_valid  out  1  high for exactly one cycle for each accepted input.

## Operation
- Mapping: thermo[i] = 1 exactly when i < binary, for i = 0..THERMO_W-1.
  - The ones are packed from the LSB with no gaps.
  - binary = 0 gives all zeros.
  - binary = N gives N ones in bits [N-1:0].
- Maximum input 2**BIN_W - 1 gives 16'h7FFF at the default width. thermo[THERMO_W-1] is therefore always 0.
  - This is intentional: bit count equals the code, with no saturation.
  - The bit is still present in the port for array alignment.
- Population count of `thermo` equals `binary` for every accepted input. Verification checks this.
- An accepted input (bin_valid = 1) loads the decoded word into the `thermo` register and sets thermo_valid.
- With bin_valid = 0:
  - `thermo` holds its last value, so the analog array keeps its setting.
  - thermo_valid is 0.
- X or Z on `binary` while bin_valid = 1 is illegal. The design does not check for it.
- No other state exists: no FSM, no counters.

## Timing
- Latency is 1 cycle. An input accepted at edge k appears on `thermo` and `thermo_valid` right after edge k.
- Throughput is one code per cycle. Back-to-back valid inputs update the output every cycle.
- Reset, sampled on a clk edge with rst = 1:
  - thermo = 0 and thermo_valid = 0 after that edge.
  - Reset takes priority over a simultaneous bin_valid.
- Reset asserted mid-stream clears the output on the next edge. The pending input is discarded.
- The first valid input after rst deasserts is accepted normally on that same edge.
- Adjacent codes (N to N+1) change exactly one output bit. An arbitrary jump changes |Δ| bits, all within the same cycle.
- `thermo` is driven directly from flops. There is no combinational path from `binary` to `thermo`.

## Structure
- Package `b2t_pkg`:
  - `BIN_W_DEFAULT` = 4.
  - Function `thermo_of(bin)` returning the reference thermometer word, shared by the RTL and the bench.
  - Typedefs `bin_t` and `thermo_t` for the default widths.
- Sub-module `b2t_comb`: purely combinational decoder, parameterized by BIN_W. Implemented as a generate loop of per-bit magnitude compares (i < binary).
- Top `b2t`: instantiates `b2t_comb` and contains the output and valid registers plus the reset logic.

## Test plan
- Reset: hold rst = 1 for 3 cycles with bin_valid = 1 and binary = 4'hF -> thermo = 16'h0000 and thermo_valid = 0 throughout.
- Exhaustive sweep: apply binary 0..15 with bin_valid = 1, one per cycle -> each result appears one cycle later.
  - Expected values: 0 -> 16'h0000, 1 -> 16'h0001, 3 -> 16'h0007, 8 -> 16'h00FF, 15 -> 16'h7FFF.
  - popcount(thermo) equals binary for every code.
- Hold: load 5, then drop bin_valid for 4 cycles while changing binary -> thermo stays 16'h001F and thermo_valid = 0.
- Large jumps: apply 15, then 0, then 15 on back-to-back cycles -> outputs 16'h7FFF, 16'h0000, 16'h7FFF on consecutive cycles, thermo_valid held high.
- Mid-stream reset: load 9 (16'h01FF), then assert rst for one cycle together with bin_valid and binary = 3 -> thermo = 16'h0000 after that edge. The next valid 3 yields 16'h0007.
- Parameter check: BIN_W = 3 with an exhaustive sweep -> 8-bit output, where 7 -> 8'h7F and 0 -> 8'h00.

Source files
------------

// File: rtl/b2t_pkg.sv
// Shared types, default widths and a reference decode for the FLB thermometer path.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package b2t_pkg;

    localparam int BIN_W_DEFAULT    = 4;
    localparam int THERMO_W_DEFAULT = 2 ** BIN_W_DEFAULT;

    typedef logic [BIN_W_DEFAULT-1:0]    bin_t;
    typedef logic [THERMO_W_DEFAULT-1:0] thermo_t;

    // Reference thermometer word at the default width: bit i set when i < bin.
    function automatic thermo_t thermo_of(input bin_t bin);
        thermo_t r;
        r = '0;
        for (int i = 0; i < THERMO_W_DEFAULT; i++) begin
            r[i] = (i < int'(bin));
        end
        return r;
    endfunction

endpackage

// File: rtl/b2t_comb.sv
// Combinational binary-to-thermometer decoder, one magnitude compare per output bit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module b2t_comb
    import b2t_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEFAULT
) (
    input  logic [BIN_W-1:0]      binary,
    output logic [2**BIN_W-1:0]   thermo
);

    localparam int THERMO_W = 2 ** BIN_W;

    // The top bit compares against a value one above the largest code, so it is
    // always 0: the number of ones equals the code, never saturating.
    genvar i;
    generate
        for (i = 0; i < THERMO_W; i++) begin : g_bit
            localparam logic [BIN_W:0] IDX = (BIN_W + 1)'(i);
            assign thermo[i] = (IDX < {1'b0, binary});
        end
    endgenerate

endmodule

// File: rtl/b2t.sv
// Registered binary-to-thermometer decoder driving unit-weighted DAC/DCO cells.
// Latency: 1 cycle from accepted bin_valid to thermo/thermo_valid.
// Backpressure: none; accepts one code per cycle, holds thermo when bin_valid is low.
module b2t
    import b2t_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      binary,
    input  logic                  bin_valid,
    output logic [2**BIN_W-1:0]   thermo,
    output logic                  thermo_valid
);

    localparam int THERMO_W = 2 ** BIN_W;

    logic [THERMO_W-1:0] thermo_nxt;

    b2t_comb #(
        .BIN_W (BIN_W)
    ) u_comb (
        .binary (binary),
        .thermo (thermo_nxt)
    );

    // Output flops: reset wins; otherwise load on valid and hold the array setting when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            thermo       <= '0;
            thermo_valid <= 1'b0;
        end else begin
            thermo_valid <= bin_valid;
            if (bin_valid) begin
                thermo <= thermo_nxt;
            end
        end
    end

endmodule

// File: tb/tb_b2t.sv
module tb_b2t;
    import b2t_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  binary;
    logic        bin_valid;
    logic [15:0] thermo;
    logic        thermo_valid;

    logic [2:0]  binary3;
    logic        bin_valid3;
    logic [7:0]  thermo3;
    logic        thermo_valid3;

    int tests  = 0;
    int failed = 0;

    // behavioural model state
    logic [15:0] m_thermo;
    logic        m_vld;
    logic [7:0]  m3_thermo;
    logic        m3_vld;

    always #5 clk = ~clk;

    b2t u_dut (
        .clk          (clk),
        .rst          (rst),
        .binary       (binary),
        .bin_valid    (bin_valid),
        .thermo       (thermo),
        .thermo_valid (thermo_valid)
    );

    b2t #(.BIN_W(3)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .binary       (binary3),
        .bin_valid    (bin_valid3),
        .thermo       (thermo3),
        .thermo_valid (thermo_valid3)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [3:0]  b;
        logic [15:0] et;
        logic        ev;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // n ones from the LSB, computed arithmetically
    function automatic logic [31:0] ones(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // model for one clock edge, default-width instance
    task automatic model16(input logic r, input logic v, input logic [3:0] b);
        if (r) begin
            m_thermo = '0;
            m_vld    = 1'b0;
        end else begin
            m_vld = v;
            if (v) m_thermo = 16'(ones(int'(b)));
        end
    endtask

    task automatic model8(input logic r, input logic v, input logic [2:0] b);
        if (r) begin
            m3_thermo = '0;
            m3_vld    = 1'b0;
        end else begin
            m3_vld = v;
            if (v) m3_thermo = 8'(ones(int'(b)));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] b,
                                input logic [15:0] et, input logic ev, input string n);
        vec_t x;
        x.r = r; x.v = v; x.b = b; x.et = et; x.ev = ev; x.name = n;
        return x;
    endfunction

    initial begin
        rst = 1'b1; bin_valid = 1'b0; binary = '0;
        bin_valid3 = 1'b0; binary3 = '0;
        m_thermo = '0; m_vld = 1'b0; m3_thermo = '0; m3_vld = 1'b0;

        // reset, key sweep points, hold, large jumps, mid-stream reset
        vecs.push_back(mk(1, 1, 4'hF, 16'h0000, 0, "reset0"));
        vecs.push_back(mk(1, 1, 4'hF, 16'h0000, 0, "reset1"));
        vecs.push_back(mk(1, 1, 4'hF, 16'h0000, 0, "reset2"));
        vecs.push_back(mk(0, 1, 4'd0, 16'h0000, 1, "code0"));
        vecs.push_back(mk(0, 1, 4'd1, 16'h0001, 1, "code1"));
        vecs.push_back(mk(0, 1, 4'd3, 16'h0007, 1, "code3"));
        vecs.push_back(mk(0, 1, 4'd8, 16'h00FF, 1, "code8"));
        vecs.push_back(mk(0, 1, 4'd15, 16'h7FFF, 1, "code15"));
        vecs.push_back(mk(0, 1, 4'd5, 16'h001F, 1, "hold_load5"));
        vecs.push_back(mk(0, 0, 4'd2, 16'h001F, 0, "hold1"));
        vecs.push_back(mk(0, 0, 4'd15, 16'h001F, 0, "hold2"));
        vecs.push_back(mk(0, 0, 4'd0, 16'h001F, 0, "hold3"));
        vecs.push_back(mk(0, 0, 4'd9, 16'h001F, 0, "hold4"));
        vecs.push_back(mk(0, 1, 4'd15, 16'h7FFF, 1, "jump15a"));
        vecs.push_back(mk(0, 1, 4'd0, 16'h0000, 1, "jump0"));
        vecs.push_back(mk(0, 1, 4'd15, 16'h7FFF, 1, "jump15b"));
        vecs.push_back(mk(0, 1, 4'd9, 16'h01FF, 1, "mid_load9"));
        vecs.push_back(mk(1, 1, 4'd3, 16'h0000, 0, "mid_rst"));
        vecs.push_back(mk(0, 1, 4'd3, 16'h0007, 1, "post_rst3"));
        vecs.push_back(mk(0, 0, 4'd12, 16'h0007, 0, "post_rst_idle"));

        foreach (vecs[k]) begin
            rst = vecs[k].r; bin_valid = vecs[k].v; binary = vecs[k].b;
            tick();
            model16(vecs[k].r, vecs[k].v, vecs[k].b);
            model8(vecs[k].r, 1'b0, 3'd0);
            check({vecs[k].name, "_thermo"}, 32'(thermo), 32'(vecs[k].et));
            check({vecs[k].name, "_vld"}, 32'(thermo_valid), 32'(vecs[k].ev));
        end

        // exhaustive sweep with popcount and package function cross-check
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            bin_valid = 1'b1; binary = 4'(n);
            tick();
            model16(1'b0, 1'b1, 4'(n));
            check($sformatf("sweep%0d_thermo", n), 32'(thermo), 32'(m_thermo));
            check($sformatf("sweep%0d_pop", n), 32'($countones(thermo)), 32'(n));
            check($sformatf("sweep%0d_vld", n), 32'(thermo_valid), 32'd1);
            check($sformatf("pkgfn%0d", n), 32'(thermo_of(4'(n))), ones(n));
        end

        // randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 19) == 0);
            bin_valid = $urandom_range(0, 2) != 0;
            binary    = 4'($urandom);
            tick();
            model16(rst, bin_valid, binary);
            check("rand_thermo", 32'(thermo), 32'(m_thermo));
            check("rand_vld", 32'(thermo_valid), 32'(m_vld));
            if (thermo_valid) check("rand_pop", 32'($countones(thermo)), 32'(binary));
        end

        // narrow instance: exhaustive sweep
        rst = 1'b0; bin_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            bin_valid3 = 1'b1; binary3 = 3'(n);
            tick();
            model8(1'b0, 1'b1, 3'(n));
            check($sformatf("w3_sweep%0d_thermo", n), 32'(thermo3), 32'(m3_thermo));
            check($sformatf("w3_sweep%0d_vld", n), 32'(thermo_valid3), 32'd1);
        end
        bin_valid3 = 1'b0;
        tick();
        check("w3_max_hold", 32'(thermo3), 32'h7F);
        check("w3_idle_vld", 32'(thermo_valid3), 32'd0);
        bin_valid3 = 1'b1; binary3 = 3'd0;
        tick();
        check("w3_zero", 32'(thermo3), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
